// File: rtl/hazard_pkg.sv
// Shared definitions for hazard detection: RV32I opcodes, slot record layouts and
// hazard_op bit positions (also consumed by the forward unit).
package hazard_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam int unsigned HOP_RS1 = 0;
    localparam int unsigned HOP_RS2 = 1;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses_rs1;
        logic       uses_rs2;
        logic [4:0] rd;
        logic       reg_write;
    } ex_slot_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
    } mem_slot_t;

    function automatic mem_slot_t ex_to_mem(input ex_slot_t ex);
        mem_slot_t m;
        m.valid     = ex.valid;
        m.rd        = ex.rd;
        m.reg_write = ex.reg_write;
        return m;
    endfunction

endpackage

// File: rtl/hazard_compare.sv
// Matches one consumer source index against the MEM-stage destination,
// gated by consumer/producer validity and excluding x0.
module hazard_compare
    import hazard_pkg::*;
(
    input  logic       i_src_valid,
    input  logic       i_uses,
    input  logic [4:0] i_src,
    input  mem_slot_t  i_mem,
    output logic       o_match
);

    assign o_match = i_src_valid && i_uses && i_mem.valid && i_mem.reg_write
                     && (i_mem.rd != 5'd0) && (i_mem.rd == i_src);

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection for the five-stage pipeline: MEM->EX forward requests,
// one-cycle IF/ID stall on distance-2 dependencies, flush/freeze handling, stall counter.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_id_valid,
    input  logic [6:0]      i_id_opcode,
    input  logic [4:0]      i_id_rs1,
    input  logic [4:0]      i_id_rs2,
    input  logic            i_id_uses_rs1,
    input  logic            i_id_uses_rs2,
    input  logic [4:0]      i_id_rd,
    input  logic            i_id_reg_write,
    input  logic            i_flush,
    input  logic            i_mem_busy,
    output logic [1:0]      o_hazard_op,
    output logic            o_stall,
    output logic            o_bubble,
    output logic [XLEN-1:0] o_stall_count
);

    ex_slot_t        r_ex;
    ex_slot_t        w_ex_next;
    mem_slot_t       r_mem;
    mem_slot_t       w_mem_next;
    logic [XLEN-1:0] r_count;
    logic [XLEN-1:0] w_count_next;

    logic w_ex_m1;
    logic w_ex_m2;
    logic w_id_m1;
    logic w_id_m2;
    logic w_stall;
    logic w_unused_opcode;

    // Write intent arrives pre-decoded on i_id_reg_write; the opcode is not needed here.
    assign w_unused_opcode = ^i_id_opcode;

    hazard_compare u_cmp_ex_rs1 (
        .i_src_valid (r_ex.valid),
        .i_uses      (r_ex.uses_rs1),
        .i_src       (r_ex.rs1),
        .i_mem       (r_mem),
        .o_match     (w_ex_m1)
    );

    hazard_compare u_cmp_ex_rs2 (
        .i_src_valid (r_ex.valid),
        .i_uses      (r_ex.uses_rs2),
        .i_src       (r_ex.rs2),
        .i_mem       (r_mem),
        .o_match     (w_ex_m2)
    );

    hazard_compare u_cmp_id_rs1 (
        .i_src_valid (i_id_valid),
        .i_uses      (i_id_uses_rs1),
        .i_src       (i_id_rs1),
        .i_mem       (r_mem),
        .o_match     (w_id_m1)
    );

    hazard_compare u_cmp_id_rs2 (
        .i_src_valid (i_id_valid),
        .i_uses      (i_id_uses_rs2),
        .i_src       (i_id_rs2),
        .i_mem       (r_mem),
        .o_match     (w_id_m2)
    );

    // The producer in MEM will be in WB when the ID consumer would reach EX.
    assign w_stall = (w_id_m1 || w_id_m2) && !i_flush && !i_mem_busy;

    always_comb begin
        o_hazard_op          = 2'b00;
        o_hazard_op[HOP_RS1] = w_ex_m1;
        o_hazard_op[HOP_RS2] = w_ex_m2;
    end

    assign o_stall       = w_stall;
    assign o_bubble      = w_stall;
    assign o_stall_count = r_count;

    always_comb begin
        w_ex_next    = r_ex;
        w_mem_next   = r_mem;
        w_count_next = r_count;
        if (!i_mem_busy) begin
            w_mem_next = ex_to_mem(r_ex);
            if (i_flush || w_stall) begin
                w_ex_next = '0;
            end else begin
                w_ex_next = '{valid:     i_id_valid,
                              rs1:       i_id_rs1,
                              rs2:       i_id_rs2,
                              uses_rs1:  i_id_uses_rs1,
                              uses_rs2:  i_id_uses_rs2,
                              rd:        i_id_rd,
                              reg_write: i_id_reg_write};
            end
            if (w_stall && (r_count != '1)) begin
                w_count_next = r_count + XLEN'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ex    <= '0;
            r_mem   <= '0;
            r_count <= '0;
        end else begin
            r_ex    <= w_ex_next;
            r_mem   <= w_mem_next;
            r_count <= w_count_next;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed pipeline scenarios plus randomized
// traffic, checked against an instruction-level reference model.
module tb_hazard_unit;
    import hazard_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs1, id_uses_rs2, id_reg_write;
    logic        flush, mem_busy;
    logic [1:0]  hop, hop_s;
    logic        stall, bubble, stall_s, bubble_s;
    logic [31:0] cnt;
    logic [2:0]  cnt_s;

    always #5 clk = ~clk;

    hazard_unit u_dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_id_valid     (id_valid),
        .i_id_opcode    (id_opcode),
        .i_id_rs1       (id_rs1),
        .i_id_rs2       (id_rs2),
        .i_id_uses_rs1  (id_uses_rs1),
        .i_id_uses_rs2  (id_uses_rs2),
        .i_id_rd        (id_rd),
        .i_id_reg_write (id_reg_write),
        .i_flush        (flush),
        .i_mem_busy     (mem_busy),
        .o_hazard_op    (hop),
        .o_stall        (stall),
        .o_bubble       (bubble),
        .o_stall_count  (cnt)
    );

    // Narrow counter copy so saturation is reachable.
    hazard_unit #(.XLEN(3)) u_dut_small (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_id_valid     (id_valid),
        .i_id_opcode    (id_opcode),
        .i_id_rs1       (id_rs1),
        .i_id_rs2       (id_rs2),
        .i_id_uses_rs1  (id_uses_rs1),
        .i_id_uses_rs2  (id_uses_rs2),
        .i_id_rd        (id_rd),
        .i_id_reg_write (id_reg_write),
        .i_flush        (flush),
        .i_mem_busy     (mem_busy),
        .o_hazard_op    (hop_s),
        .o_stall        (stall_s),
        .o_bubble       (bubble_s),
        .o_stall_count  (cnt_s)
    );

    typedef struct {
        bit v;
        int rd;
        int rs1;
        int rs2;
        bit u1;
        bit u2;
        bit w;
    } instr_t;

    int          checks   = 0;
    int          failures = 0;
    instr_t      m_ex, m_mem, idle_i;
    longint      m_cnt, m_cnt_s;
    logic [1:0]  obs_hop;
    logic        obs_stall;
    bit          last_stall;

    function automatic instr_t mk(input int rd, input int rs1, input int rs2,
                                  input bit u1, input bit u2, input bit w);
        instr_t i;
        i.v = 1'b1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.u1 = u1; i.u2 = u2; i.w = w;
        return i;
    endfunction

    // Does producer p deliver a nonzero register r?
    function automatic bit writes(input instr_t p, input int r);
        return p.v && p.w && (p.rd != 0) && (p.rd == r);
    endfunction

    function automatic bit depends(input instr_t c, input instr_t p);
        return c.v && ((c.u1 && writes(p, c.rs1)) || (c.u2 && writes(p, c.rs2)));
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.v  = ($urandom_range(0, 9) != 0);
        i.rd = $urandom_range(0, 7);
        i.rs1 = $urandom_range(0, 7);
        i.rs2 = $urandom_range(0, 7);
        i.u1 = $urandom_range(0, 1) == 1;
        i.u2 = $urandom_range(0, 1) == 1;
        i.w  = $urandom_range(0, 3) != 0;
        return i;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input instr_t in, input bit fl, input bit busy);
        id_valid     = in.v;
        id_rd        = 5'(in.rd);
        id_rs1       = 5'(in.rs1);
        id_rs2       = 5'(in.rs2);
        id_uses_rs1  = in.u1;
        id_uses_rs2  = in.u2;
        id_reg_write = in.w;
        id_opcode    = in.w ? OP_REG : OP_STORE;
        flush        = fl;
        mem_busy     = busy;
    endtask

    task automatic model_reset();
        m_ex    = idle_i;
        m_mem   = idle_i;
        m_cnt   = 0;
        m_cnt_s = 0;
    endtask

    task automatic model_check(input instr_t in, input bit fl, input bit busy);
        logic [1:0] eh;
        eh[0] = m_ex.v && m_ex.u1 && writes(m_mem, m_ex.rs1);
        eh[1] = m_ex.v && m_ex.u2 && writes(m_mem, m_ex.rs2);
        last_stall = depends(in, m_mem) && !fl && !busy;
        chk("hazard_op", 32'(hop), 32'(eh));
        chk("stall", 32'(stall), 32'(last_stall));
        chk("bubble", 32'(bubble), 32'(last_stall));
        chk("stall_count", cnt, 32'(m_cnt));
        chk("stall_count_small", 32'(cnt_s), 32'(m_cnt_s));
        obs_hop   = hop;
        obs_stall = stall;
    endtask

    task automatic model_update(input instr_t in, input bit fl, input bit busy);
        if (!busy) begin
            if (last_stall) begin
                if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
                if (m_cnt_s < 7) m_cnt_s++;
            end
            m_mem = m_ex;
            m_ex  = (fl || last_stall) ? idle_i : in;
        end
    endtask

    task automatic cycle(input instr_t in, input bit fl, input bit busy);
        @(negedge clk);
        drive(in, fl, busy);
        #1;
        model_check(in, fl, busy);
        @(posedge clk);
        model_update(in, fl, busy);
    endtask

    initial begin
        instr_t lw5, nop_i, add_dep, cur;
        longint base;
        bit     fl, busy;

        idle_i = '{default: 0};
        lw5    = mk(5, 1, 0, 1, 0, 1);
        nop_i  = mk(0, 0, 0, 1, 0, 1);
        add_dep = mk(6, 5, 5, 1, 1, 1);

        reset = 1'b1;
        drive(idle_i, 1'b0, 1'b0);
        model_reset();
        #1;
        chk("reset_hop", 32'(hop), 32'h0);
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_bubble", 32'(bubble), 32'h0);
        chk("reset_count", cnt, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // add x5,x1,x2 ; sub x6,x5,x3
        cycle(mk(5, 1, 2, 1, 1, 1), 0, 0);
        cycle(mk(6, 5, 3, 1, 1, 1), 0, 0);
        cycle(idle_i, 0, 0);
        chk("fwd_rs1_hop", 32'(obs_hop), 32'h1);
        chk("fwd_rs1_stall", 32'(obs_stall), 32'h0);

        // add x5 ; or x7,x4,x5  then  add x5 ; and x8,x5,x5
        cycle(mk(5, 1, 2, 1, 1, 1), 0, 0);
        cycle(mk(7, 4, 5, 1, 1, 1), 0, 0);
        cycle(idle_i, 0, 0);
        chk("fwd_rs2_hop", 32'(obs_hop), 32'h2);
        cycle(idle_i, 0, 0);
        cycle(mk(5, 1, 2, 1, 1, 1), 0, 0);
        cycle(mk(8, 5, 5, 1, 1, 1), 0, 0);
        cycle(idle_i, 0, 0);
        chk("fwd_both_hop", 32'(obs_hop), 32'h3);

        // addi x0,x1,4 ; sub x6,x0,x0 ; reader of x0 at distance 2
        cycle(mk(0, 1, 0, 1, 0, 1), 0, 0);
        cycle(mk(6, 0, 0, 1, 1, 1), 0, 0);
        cycle(mk(9, 0, 0, 1, 1, 1), 0, 0);
        chk("x0_hop", 32'(obs_hop), 32'h0);
        chk("x0_stall", 32'(obs_stall), 32'h0);
        cycle(idle_i, 0, 0);
        cycle(idle_i, 0, 0);

        // lw x5 ; nop ; add x6,x5,x5
        base = m_cnt;
        cycle(lw5, 0, 0);
        cycle(nop_i, 0, 0);
        cycle(add_dep, 0, 0);
        chk("d2_stall_first", 32'(obs_stall), 32'h1);
        cycle(add_dep, 0, 0);
        chk("d2_stall_second", 32'(obs_stall), 32'h0);
        cycle(idle_i, 0, 0);
        chk("d2_add_in_ex_hop", 32'(obs_hop), 32'h0);
        chk("d2_count", cnt, 32'(base + 1));

        // distance-2 with flush in the would-be stall cycle
        base = m_cnt;
        cycle(lw5, 0, 0);
        cycle(nop_i, 0, 0);
        cycle(add_dep, 1, 0);
        chk("flush_stall", 32'(obs_stall), 32'h0);
        cycle(idle_i, 0, 0);
        cycle(mk(9, 6, 0, 1, 0, 1), 0, 0);
        chk("flush_ex_killed", 32'(obs_stall), 32'h0);
        chk("flush_count", cnt, 32'(base));

        // dependent pair frozen by mem_busy, with a distance-2 reader waiting in ID
        cycle(mk(5, 1, 2, 1, 1, 1), 0, 0);
        cycle(mk(6, 5, 3, 1, 1, 1), 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(mk(7, 5, 0, 1, 0, 1), 0, 1);
            chk("busy_hop", 32'(obs_hop), 32'h1);
            chk("busy_stall", 32'(obs_stall), 32'h0);
        end
        cycle(mk(7, 5, 0, 1, 0, 1), 0, 0);
        chk("busy_release_hop", 32'(obs_hop), 32'h1);
        chk("busy_release_stall", 32'(obs_stall), 32'h1);
        cycle(mk(7, 5, 0, 1, 0, 1), 0, 0);
        chk("busy_release_once", 32'(obs_stall), 32'h0);
        cycle(idle_i, 0, 0);

        // reset pulsed asynchronously in the middle of a stall cycle
        cycle(lw5, 0, 0);
        cycle(nop_i, 0, 0);
        @(negedge clk);
        drive(add_dep, 0, 0);
        #1;
        model_check(add_dep, 0, 0);
        chk("rst_pre_stall", 32'(stall), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_async_hop", 32'(hop), 32'h0);
        chk("rst_async_stall", 32'(stall), 32'h0);
        chk("rst_async_bubble", 32'(bubble), 32'h0);
        chk("rst_async_count", cnt, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cycle(mk(5, 1, 2, 1, 1, 1), 0, 0);
        cycle(mk(6, 5, 3, 1, 1, 1), 0, 0);
        cycle(idle_i, 0, 0);
        chk("rst_after_hop", 32'(obs_hop), 32'h1);

        // drive the narrow counter into saturation
        for (int i = 0; i < 9; i++) begin
            cycle(lw5, 0, 0);
            cycle(nop_i, 0, 0);
            cycle(add_dep, 0, 0);
            cycle(add_dep, 0, 0);
        end
        chk("sat_small", 32'(cnt_s), 32'h7);
        chk("sat_wide", cnt, 32'(m_cnt));

        // randomized traffic; ID is held while stalled or frozen
        cur = rand_instr();
        for (int i = 0; i < 400; i++) begin
            fl   = ($urandom_range(0, 9) == 0);
            busy = ($urandom_range(0, 6) == 0);
            cycle(cur, fl, busy);
            if (!(busy || last_stall)) cur = rand_instr();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
